// File: rtl/button_bounce_gen.sv
// ---------------------------------------------------------------------------
// button_bounce_gen
//
// Emulates a mechanical push-button contact so a debouncer can be exercised
// in simulation or on a board. When the requested clean level (target)
// differs from the emitted contact level (noisy), the block makes the first
// transition immediately. It then adds 2*N_BOUNCES extra toggles, each
// separated by a gap of GAP_MIN + (random 0 .. 2^GAP_BITS-1) cycles. It
// waits HOLD quiet cycles and then pulses settled.
//
// Parameters
//   N_BOUNCES  extra toggle pairs per level change (0..15)
//   GAP_MIN    minimum cycles between consecutive transitions (1..65535)
//   GAP_BITS   width of the random gap extension (0..8, 0 = fixed gap)
//   HOLD       quiet cycles after the last transition before settled
//   SEED       LFSR reset value (nonzero)
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-high reset
//   target     clean requested button level, synchronous to clk
//   bounce_en  1 = emulate bounce, 0 = noisy follows target directly
//   noisy      emulated contact signal (registered)
//   busy       high while a burst or its settle window is in progress
//   settled    one-cycle pulse once noisy has been quiet for HOLD cycles
//   state_dbg  current FSM state (0 = IDLE, 1 = BOUNCE, 2 = SETTLE)
// ---------------------------------------------------------------------------
module button_bounce_gen #(
    parameter int          N_BOUNCES = 2,
    parameter int          GAP_MIN   = 4,
    parameter int          GAP_BITS  = 4,
    parameter int          HOLD      = 8,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       target,
    input  logic       bounce_en,
    output logic       noisy,
    output logic       busy,
    output logic       settled,
    output logic [1:0] state_dbg
);

    // Largest gap the random extension can produce.
    localparam int GAP_MAX = GAP_MIN + (1 << GAP_BITS) - 1;
    localparam int GW      = $clog2(GAP_MAX + 1);
    localparam int HW      = $clog2(HOLD + 1);
    // One shared down-counter times both the inter-transition gaps and the
    // settle window, so it is sized for whichever of the two is longer.
    localparam int CW      = (GW > HW) ? GW : HW;
    // Enough for 2*15 remaining toggles.
    localparam int RW      = 5;

    // Selects the low GAP_BITS bits of the LFSR. With GAP_BITS = 0 the mask
    // is all zeros and the gap collapses to GAP_MIN.
    localparam logic [15:0] EXT_MASK = 16'((32'd1 << GAP_BITS) - 32'd1);

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t         state;
    logic [15:0]    lfsr;
    logic [15:0]    lfsr_next;
    logic [15:0]    gap_ext;
    logic [CW-1:0]  gap_val;
    logic [CW-1:0]  tmr;
    logic [RW-1:0]  remain;

    assign state_dbg = state;

    // The LFSR free-runs from reset; its value at the edge of a transition
    // picks the gap that leads to the next transition.
    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]};
        if (lfsr[0]) begin
            lfsr_next = lfsr_next ^ LFSR_MASK;
        end
    end

    always_comb begin
        gap_ext = lfsr & EXT_MASK;
        gap_val = CW'(GAP_MIN) + CW'(gap_ext);
    end

    // Timer convention: a value v loaded at edge t expires at edge t+v.
    // The action happens on the edge where the timer reads 1, which gives
    // exactly v cycles between the two events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            noisy   <= 1'b0;
            busy    <= 1'b0;
            settled <= 1'b0;
            lfsr    <= SEED;
            tmr     <= '0;
            remain  <= '0;
        end else begin
            lfsr    <= lfsr_next;
            settled <= 1'b0;

            case (state)
                IDLE: begin
                    if (!bounce_en) begin
                        // Pass-through mode: no burst, no settled pulse.
                        noisy <= target;
                    end else if (target != noisy) begin
                        // The first transition happens on this very edge.
                        noisy  <= target;
                        remain <= RW'(2 * N_BOUNCES);
                        busy   <= 1'b1;
                        if (N_BOUNCES == 0) begin
                            state <= SETTLE;
                            tmr   <= CW'(HOLD);
                        end else begin
                            state <= BOUNCE;
                            tmr   <= gap_val;
                        end
                    end
                end

                BOUNCE: begin
                    // target and bounce_en are ignored until back in IDLE.
                    if (tmr == CW'(1)) begin
                        noisy  <= ~noisy;
                        remain <= remain - RW'(1);
                        if (remain == RW'(1)) begin
                            // Even number of toggles after the first
                            // transition, so noisy ends at the entry target.
                            state <= SETTLE;
                            tmr   <= CW'(HOLD);
                        end else begin
                            tmr <= gap_val;
                        end
                    end else begin
                        tmr <= tmr - CW'(1);
                    end
                end

                SETTLE: begin
                    if (tmr == CW'(1)) begin
                        // Back to IDLE on the pulse edge, so a pending target
                        // difference starts a new burst on the next edge.
                        settled <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                        tmr     <= '0;
                    end else begin
                        tmr <= tmr - CW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    tmr   <= '0;
                end
            endcase
        end
    end

endmodule
